branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor that produces the `branch_taken` guess carried down the pipe alongside each instruction, and learns from the branch outcomes resolved in Execute. It combines a direct-mapped branch target buffer (tag, target, valid) with one 2-bit saturating counter per entry. Fetch queries it combinationally every cycle. Execute writes back one resolved branch per cycle. After reset, a sequential sweep clears the table before predictions are enabled.

## Interface
- `INDEX_BITS`, default 6: table holds 2^INDEX_BITS entries.
- `TAG_BITS`, default 8: tag width stored per entry.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous and active-high.
- `if_pc`  in  `WORD`  PC being fetched.
- `predict_taken`  out  1  guess for `if_pc`.
- `predict_target`  out  `WORD`  next fetch PC: stored target if `predict_taken`, else `if_pc + 4`.
- `init_busy`  out  1  table sweep in progress; predictions are suppressed while high.
- `ex_update`  in  1  Execute presents a resolved conditional branch or jump this cycle.
- `ex_branch_pc`  in  `WORD`  PC of the resolved instruction.
- `ex_taken`  in  1  actual direction.
- `ex_target`  in  `WORD`  actual taken target.

## Operation
- Index is `pc[INDEX_BITS+1:2]`; tag is `pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`. `pc[1:0]` is ignored.
- Hit means the entry is valid and its stored tag equals the lookup tag.
- Prediction: `predict_taken = !init_busy && hit && counter[1]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update when `ex_update` is high and `init_busy` is low:
  - Hit, `ex_taken`: counter saturates upward; target is overwritten with `ex_target`.
  - Hit, not taken: counter saturates downward; target is unchanged.
  - Miss, `ex_taken`: allocate the entry (valid=1, new tag, `ex_target`, counter=10), evicting any other tag.
  - Miss, not taken: no change.
- `ex_update` while `init_busy` is high is dropped.
- FSM:
  - INIT: counter `sweep_idx` writes entry `sweep_idx` to valid=0, counter=01, tag=0, target=0. After the last index (2^INDEX_BITS−1) is written, go to RUN.
  - RUN: normal operation. Only `rst` leaves RUN.
  - `rst` in either state forces INIT with `sweep_idx`=0.

## Timing
- Reset values: `init_busy`=1; `predict_taken`=0; `predict_target`=`if_pc + 4`.
- `init_busy` stays high for exactly 2^INDEX_BITS cycles after the cycle `rst` is sampled high (64 by default). It falls in the cycle after the last index is written.
- Lookup is purely combinational from `if_pc` and current table state, with zero-cycle latency.
- An update takes effect at the `clk` edge that samples it, so a lookup in the following cycle sees it.
- Same-cycle lookup and update to the same index: see Configuration.
- `rst` asserted mid-sweep restarts the sweep from index 0.
- `rst` asserted in RUN discards all learned state.
- `predict_target` addition wraps modulo 2^32.

## Configuration
- `BP_BYPASS_EN` defined: when `ex_update` is high and `ex_branch_pc` has the same index as `if_pc`, the lookup sees the post-update entry in the same cycle (write-through forwarding).
- `BP_BYPASS_EN` undefined: the lookup sees only registered state; the update is visible from the next cycle.

## Test plan
- **Reset sweep:** pulse `rst` for 1 cycle. Required: `init_busy` is high for 64 cycles. During the sweep, `if_pc`=0x100 gives `predict_taken`=0 and `predict_target`=0x104.
- **Allocate and predict:** with the block in RUN, apply `ex_update`, pc=0x40, taken, target 0x80. Next cycle, `if_pc`=0x40 gives `predict_taken`=1 and `predict_target`=0x80.
- **Saturation:** from counter 10, apply 3 taken updates, then 1 not-taken. Required: prediction remains taken (11→10). A second not-taken gives 01, so `predict_taken`=0.
- **Aliasing:** allocate pc=0x40, then allocate pc=0x440 (same index, different tag). Required: lookup of 0x40 misses and predicts 0x44; lookup of 0x440 hits.
- **Same-cycle update and lookup:** apply `ex_update` (pc=0x40, taken, 0x80) with `if_pc`=0x40 in the same cycle on a cleared table. Required: `predict_taken`=1 with `BP_BYPASS_EN` defined, 0 without it.
- **Reset mid-operation:** after learning pc=0x40, assert `rst` at sweep index 10, and again in RUN. Required: the sweep restarts at 0, and 0x40 predicts not-taken afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; optional same-cycle forwarding under BP_BYPASS_EN
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    output logic        init_busy,
    input  logic        ex_update,
    input  logic [31:0] ex_branch_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t                r_state, w_next_state;
    logic [INDEX_BITS-1:0] r_sweep_idx;
    logic                  r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [31:0]           r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [INDEX_BITS-1:0] w_if_idx, w_ex_idx;
    logic [TAG_BITS-1:0]   w_if_tag, w_ex_tag, w_upd_tag, w_lk_tag;
    logic                  w_ex_hit, w_we, w_fwd, w_upd_valid, w_lk_valid, w_hit;
    logic [31:0]           w_upd_target, w_lk_target;
    logic [1:0]            w_cur_ctr, w_upd_ctr, w_lk_ctr;
    logic                  w_unused;
    assign w_unused  = ^{if_pc[31:TAG_HI+1], if_pc[1:0], ex_branch_pc[31:TAG_HI+1], ex_branch_pc[1:0]};
    assign w_if_idx  = if_pc[TAG_LO-1:2];
    assign w_if_tag  = if_pc[TAG_HI:TAG_LO];
    assign w_ex_idx  = ex_branch_pc[TAG_LO-1:2];
    assign w_ex_tag  = ex_branch_pc[TAG_HI:TAG_LO];
    assign init_busy = (r_state == ST_INIT);
    // Leave the sweep once the last index has been written
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_INIT && &r_sweep_idx) w_next_state = ST_RUN;
    end
    // State register and sweep counter; reset always restarts the sweep at index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_next_state;
            if (r_state == ST_INIT) r_sweep_idx <= r_sweep_idx + INDEX_BITS'(1);
        end
    end
    // Post-update view of the entry addressed by Execute; equals stored state when nothing is written
    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_we         = ex_update && !init_busy && (w_ex_hit || ex_taken);
    assign w_cur_ctr    = r_ctr[w_ex_idx];
    assign w_upd_valid  = w_we ? 1'b1 : r_valid[w_ex_idx];
    assign w_upd_tag    = w_we ? w_ex_tag : r_tag[w_ex_idx];
    assign w_upd_target = (w_we && ex_taken) ? ex_target : r_target[w_ex_idx];
    assign w_upd_ctr    = !w_we     ? w_cur_ctr :
                          !w_ex_hit ? 2'b10 :
                          ex_taken  ? ((w_cur_ctr == 2'b11) ? 2'b11 : w_cur_ctr + 2'd1) :
                                      ((w_cur_ctr == 2'b00) ? 2'b00 : w_cur_ctr - 2'd1);
    // Table writes: sweep clears one entry per cycle, otherwise Execute updates land here
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_valid[r_sweep_idx]  <= 1'b0;
            r_tag[r_sweep_idx]    <= '0;
            r_target[r_sweep_idx] <= '0;
            r_ctr[r_sweep_idx]    <= 2'b01;
        end else if (w_we) begin
            r_valid[w_ex_idx]  <= w_upd_valid;
            r_tag[w_ex_idx]    <= w_upd_tag;
            r_target[w_ex_idx] <= w_upd_target;
            r_ctr[w_ex_idx]    <= w_upd_ctr;
        end
    end
`ifdef BP_BYPASS_EN
    assign w_fwd = ex_update && !init_busy && (w_ex_idx == w_if_idx);
`else
    assign w_fwd = 1'b0;
`endif
    assign w_lk_valid     = w_fwd ? w_upd_valid  : r_valid[w_if_idx];
    assign w_lk_tag       = w_fwd ? w_upd_tag    : r_tag[w_if_idx];
    assign w_lk_target    = w_fwd ? w_upd_target : r_target[w_if_idx];
    assign w_lk_ctr       = w_fwd ? w_upd_ctr    : r_ctr[w_if_idx];
    assign w_hit          = w_lk_valid && (w_lk_tag == w_if_tag);
    assign predict_taken  = !init_busy && w_hit && w_lk_ctr[1];
    assign predict_target = predict_taken ? w_lk_target : if_pc + 32'd4;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table plus scoreboard checks for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] if_pc = 32'h0, ex_branch_pc = 32'h0, ex_target = 32'h0;
    logic        ex_update = 1'b0, ex_taken = 1'b0;
    logic        predict_taken, init_busy;
    logic [31:0] predict_target;
    int          n_tests = 0, n_fail = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .predict_taken(predict_taken),
        .predict_target(predict_target), .init_busy(init_busy), .ex_update(ex_update),
        .ex_branch_pc(ex_branch_pc), .ex_taken(ex_taken), .ex_target(ex_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        upd;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] tgt;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;
    typedef struct {
        string       name;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;
    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        if_pc = v.pc; ex_update = v.upd; ex_branch_pc = v.epc; ex_taken = v.tk; ex_target = v.tgt;
        sb.push_back('{name, v.e_tk, v.e_tgt});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, " taken"}, {31'b0, predict_taken}, {31'b0, e.tk});
        chk({e.name, " target"}, predict_target, e.tgt);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        apply(name, '{pc, 1'b0, 32'h0, 1'b0, 32'h0, tk, tgt});
    endtask

    task automatic update(input string name, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        apply(name, '{32'h204, 1'b1, pc, tk, tgt, 1'b0, 32'h208});
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int cnt = 0;
        if_pc = 32'h100;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            if (i == 0 || i == 63) begin
                chk({name, " busy taken"}, {31'b0, predict_taken}, 32'h0);
                chk({name, " busy target"}, predict_target, 32'h104);
            end
            cnt++;
        end
        chk({name, " busy cycles"}, cnt, 64);
    endtask

    initial begin
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'h80,  1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'h80,  1'b0, 32'h208});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'h80,  1'b0, 32'h208});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'h90,  1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h90});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b0, 32'h123, 1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h90});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h208});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'hA0,  1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44});
        tbl.push_back('{32'h204,      1'b1, 32'h40,  1'b1, 32'hA0,  1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hA0});
        tbl.push_back('{32'h204,      1'b1, 32'h80,  1'b0, 32'h300, 1'b0, 32'h208});
        tbl.push_back('{32'h80,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h84});
        tbl.push_back('{32'h204,      1'b1, 32'h440, 1'b1, 32'h500, 1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44});
        tbl.push_back('{32'h440,      1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500});
        tbl.push_back('{32'h441,      1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500});
        tbl.push_back('{32'h204,      1'b0, 32'h40,  1'b1, 32'h600, 1'b0, 32'h208});
        tbl.push_back('{32'h40,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44});
        tbl.push_back('{32'hFFFFFFFC, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pulse_rst();
        wait_sweep("reset sweep");

        for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

        pulse_rst();
        wait_sweep("resweep");
`ifdef BP_BYPASS_EN
        apply("same cycle", '{32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80});
`else
        apply("same cycle", '{32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44});
`endif
        lookup("after same cycle", 32'h40, 1'b1, 32'h80);

        pulse_rst();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("busy before mid reset", {31'b0, init_busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_sweep("mid-sweep reset");
        lookup("after mid reset", 32'h40, 1'b0, 32'h44);

        update("relearn", 32'h40, 1'b1, 32'h80);
        lookup("relearned", 32'h40, 1'b1, 32'h80);
        pulse_rst();
        ex_update = 1'b1; ex_branch_pc = 32'h40; ex_taken = 1'b1; ex_target = 32'h88;
        wait_sweep("run reset");
        ex_update = 1'b0;
        lookup("after run reset", 32'h40, 1'b0, 32'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
